// File: rtl/vram_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vram_arbiter_if                                                   |
// | Client request/grant/read-return bundle for the frame-buffer      |
// | arbiter. master = drawing client, slave = arbiter.                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface vram_arbiter_if;
  logic        cl_req;
  logic        cl_we;
  logic [14:0] cl_addr;
  logic [7:0]  cl_wdata;
  logic        cl_ack;
  logic [7:0]  cl_rdata;
  logic        cl_rvalid;

  modport master (
    output cl_req, cl_we, cl_addr, cl_wdata,
    input  cl_ack, cl_rdata, cl_rvalid
  );

  modport slave (
    input  cl_req, cl_we, cl_addr, cl_wdata,
    output cl_ack, cl_rdata, cl_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vram_arbiter                                                      |
// | Shares a single-port 160x120x8 frame buffer between 4x-upscaled   |
// | scanout (fixed slot every 4th active pixel) and one drawing       |
// | client (all other cycles). Pixel output is 3 cycles behind the    |
// | timing inputs; syncs and active flag are delayed to match.        |
// | Option macro: VRAM_BLANK_ONLY_EN - client served only in blanking |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  wire         pxl_clk,
  input  wire         reset,
  input  wire  [9:0]  hcount,
  input  wire  [9:0]  vcount,
  input  wire         hsync_in,
  input  wire         vsync_in,
  vram_arbiter_if.slave cl,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  wire  [7:0]  mem_rdata,
  output logic [7:0]  pix_color,
  output logic        pix_hsync,
  output logic        pix_vsync,
  output logic        pix_active
);

  typedef enum logic [1:0] {
    OWN_IDLE   = 2'd0,
    OWN_DISP   = 2'd1,
    OWN_CLIENT = 2'd2
  } owner_t;

  logic        active;
  logic        disp_slot;
  logic        client_window;
  logic        client_grant;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [14:0] disp_addr;
  owner_t      owner;
  owner_t      ret_d1;
  owner_t      ret_d2;
  logic        ack_q;
  logic        rvalid_q;
  logic [7:0]  rdata_q;
  logic [7:0]  color_q;
  logic [2:0]  hsync_dly;
  logic [2:0]  vsync_dly;
  logic [2:0]  active_dly;

  // Slot decision for the current cycle: display first, then client, else idle
  always_comb begin
    active    = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    disp_slot = active && (hcount[1:0] == 2'b00);
    row       = vcount[9:2];
    col       = hcount[9:2];
    // row*160 built from two shifts; max 119*160+159 fits in 15 bits
    disp_addr = ({7'd0, row} << 7) + ({7'd0, row} << 5) + {7'd0, col};
`ifdef VRAM_BLANK_ONLY_EN
    client_window = !active;
`else
    client_window = 1'b1;
`endif
    // A high ack means this request was just served; ignore it for one cycle
    client_grant = cl.cl_req && !ack_q && !disp_slot && client_window;
    owner = OWN_IDLE;
    if (disp_slot) begin
      owner = OWN_DISP;
    end else if (client_grant) begin
      owner = OWN_CLIENT;
    end
  end

  // Issue stage: register RAM command, grant pulse and return tag
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= 15'd0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'd0;
      ack_q     <= 1'b0;
      ret_d1    <= OWN_IDLE;
    end else begin
      ack_q  <= (owner == OWN_CLIENT);
      mem_we <= (owner == OWN_CLIENT) && cl.cl_we;
      case (owner)
        OWN_DISP: begin
          mem_addr <= disp_addr;
        end
        OWN_CLIENT: begin
          mem_addr  <= cl.cl_addr;
          mem_wdata <= cl.cl_wdata;
        end
        default: begin
          // Idle: address and data hold their last values
        end
      endcase
      // Client writes produce no read return
      ret_d1 <= ((owner == OWN_CLIENT) && cl.cl_we) ? OWN_IDLE : owner;
    end
  end

  // Return stages: wait out RAM latency, then steer read data by owner
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      ret_d2   <= OWN_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= 8'd0;
      color_q  <= 8'd0;
    end else begin
      ret_d2   <= ret_d1;
      rvalid_q <= (ret_d2 == OWN_CLIENT);
      if (ret_d2 == OWN_CLIENT) begin
        rdata_q <= mem_rdata;
      end
      if (ret_d2 == OWN_DISP) begin
        color_q <= mem_rdata;
      end
    end
  end

  // Three-stage delay lines aligning syncs and active flag with the colour
  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      hsync_dly  <= 3'd0;
      vsync_dly  <= 3'd0;
      active_dly <= 3'd0;
    end else begin
      hsync_dly  <= {hsync_dly[1:0], hsync_in};
      vsync_dly  <= {vsync_dly[1:0], vsync_in};
      active_dly <= {active_dly[1:0], active};
    end
  end

  assign cl.cl_ack    = ack_q;
  assign cl.cl_rvalid = rvalid_q;
  assign cl.cl_rdata  = rdata_q;
  assign pix_hsync    = hsync_dly[2];
  assign pix_vsync    = vsync_dly[2];
  assign pix_active   = active_dly[2];
  assign pix_color    = active_dly[2] ? color_q : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_vram_arbiter                                                   |
// | Directed bench: scanout addressing/alignment, client read/write,  |
// | slot conflicts, held requests, blank-only mode, reset mid-flight. |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  pix_color;
  logic        pix_hsync;
  logic        pix_vsync;
  logic        pix_active;

  int checks = 0;
  int errors = 0;
  int cur_h  = 0;
  int cur_v  = 0;

  vram_arbiter_if cl_bus ();

  vram_arbiter #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .pxl_clk    (clk),
    .reset      (reset),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .cl         (cl_bus),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_color  (pix_color),
    .pix_hsync  (pix_hsync),
    .pix_vsync  (pix_vsync),
    .pix_active (pix_active)
  );

  always #5 clk = ~clk;

  // Preloaded content of unwritten locations
  function automatic logic [7:0] pat(input logic [14:0] a);
    return (a[7:0] ^ a[14:7]) + 8'h11;
  endfunction

  bit [7:0] ram_mem     [0:32767];
  bit       ram_written [0:32767];

  // Synchronous single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (mem_we) begin
      ram_mem[mem_addr]     <= mem_wdata;
      ram_written[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_written[mem_addr] ? ram_mem[mem_addr] : pat(mem_addr);
  end

  task automatic drive_pos(input int h, input int v);
    cur_h    = h;
    cur_v    = v;
    hcount   = 10'(h);
    vcount   = 10'(v);
    hsync_in = (h >= 656) && (h < 752);
    vsync_in = (v >= 490) && (v < 492);
  endtask

  task automatic tick();
    int nh;
    int nv;
    @(posedge clk);
    #1;
    nh = cur_h + 1;
    nv = cur_v;
    if (nh == 800) begin
      nh = 0;
      nv = (cur_v == 524) ? 0 : cur_v + 1;
    end
    drive_pos(nh, nv);
  endtask

  task automatic set_req(input logic req, input logic we, input logic [14:0] addr,
                         input logic [7:0] wdata);
    cl_bus.cl_req   = req;
    cl_bus.cl_we    = we;
    cl_bus.cl_addr  = addr;
    cl_bus.cl_wdata = wdata;
  endtask

  task automatic test_reset();
    logic [44:0] outs;
    reset = 1'b1;
    set_req(1'b1, 1'b1, 15'd50, 8'h5A);
    drive_pos(8, 0);
    repeat (3) @(posedge clk);
    #1;
    outs = {mem_addr, mem_we, mem_wdata, cl_bus.cl_ack, cl_bus.cl_rvalid,
            cl_bus.cl_rdata, pix_color, pix_hsync, pix_vsync, pix_active};
    checks++;
    if (outs !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", outs);
    end
  endtask

  task automatic test_scanout();
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    drive_pos(0, 0);
    reset = 1'b0;
    tick();  // h=1
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr} !== {1'b0, 1'b0, 15'd0}) begin
      errors++;
      $display("FAIL disp_addr_h0 got %h want 0", {cl_bus.cl_ack, mem_we, mem_addr});
    end
    tick(); tick();  // h=3
    checks++;
    if ({pix_active, pix_color} !== {1'b1, 8'h11}) begin
      errors++;
      $display("FAIL pix_h3 got %h want 111", {pix_active, pix_color});
    end
    tick(); tick();  // h=5
    checks++;
    if (mem_addr !== 15'd1) begin
      errors++;
      $display("FAIL disp_addr_h4 got %0d want 1", mem_addr);
    end
    tick();  // h=6
    checks++;
    if (pix_color !== 8'h11) begin
      errors++;
      $display("FAIL pix_h6 got %h want 11", pix_color);
    end
    tick();  // h=7
    checks++;
    if (pix_color !== 8'h12) begin
      errors++;
      $display("FAIL pix_h7 got %h want 12", pix_color);
    end
    drive_pos(4, 4);
    tick();  // h=5
    checks++;
    if (mem_addr !== 15'd161) begin
      errors++;
      $display("FAIL disp_addr_h4v4 got %0d want 161", mem_addr);
    end
    tick(); tick();  // h=7
    checks++;
    if (pix_color !== 8'hB1) begin
      errors++;
      $display("FAIL pix_h4v4 got %h want b1", pix_color);
    end
    // End of visible line
    drive_pos(636, 4);
    repeat (6) tick();  // h=642
    checks++;
    if ({pix_active, pix_color} !== {1'b1, 8'h4E}) begin
      errors++;
      $display("FAIL pix_h642 got %h want 14e", {pix_active, pix_color});
    end
    tick();  // h=643
    checks++;
    if ({pix_active, pix_color} !== 9'd0) begin
      errors++;
      $display("FAIL pix_blank_h643 got %h want 0", {pix_active, pix_color});
    end
    repeat (15) tick();  // h=658
    checks++;
    if (pix_hsync !== 1'b0) begin
      errors++;
      $display("FAIL hsync_h658 got %b want 0", pix_hsync);
    end
    tick();  // h=659
    checks++;
    if (pix_hsync !== 1'b1) begin
      errors++;
      $display("FAIL hsync_h659 got %b want 1", pix_hsync);
    end
    drive_pos(0, 490);
    tick(); tick();  // h=2
    checks++;
    if (pix_vsync !== 1'b0) begin
      errors++;
      $display("FAIL vsync_early got %b want 0", pix_vsync);
    end
    tick();  // h=3
    checks++;
    if ({pix_vsync, pix_active, pix_color} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL vsync_h3 got %h want 200", {pix_vsync, pix_active, pix_color});
    end
  endtask

  task automatic test_client();
    logic exp_ack;
    drive_pos(700, 4);
    set_req(1'b1, 1'b1, 15'd100, 8'hA5);
    tick();  // h=701
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 15'd100, 8'hA5}) begin
      errors++;
      $display("FAIL wr_grant got %h want %h", {cl_bus.cl_ack, mem_we, mem_addr, mem_wdata},
               {1'b1, 1'b1, 15'd100, 8'hA5});
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    tick();  // h=702
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr} !== {1'b0, 1'b0, 15'd100}) begin
      errors++;
      $display("FAIL idle_hold got %h want %h", {cl_bus.cl_ack, mem_we, mem_addr},
               {1'b0, 1'b0, 15'd100});
    end
    set_req(1'b1, 1'b0, 15'd100, 8'd0);
    tick();  // h=703
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr} !== {1'b1, 1'b0, 15'd100}) begin
      errors++;
      $display("FAIL rd_grant got %h want %h", {cl_bus.cl_ack, mem_we, mem_addr},
               {1'b1, 1'b0, 15'd100});
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    tick();  // h=704
    checks++;
    if (cl_bus.cl_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_early got %b want 0", cl_bus.cl_rvalid);
    end
    tick();  // h=705
    checks++;
    if ({cl_bus.cl_rvalid, cl_bus.cl_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_data got %h want 1a5", {cl_bus.cl_rvalid, cl_bus.cl_rdata});
    end
    tick();  // h=706
    checks++;
    if (cl_bus.cl_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rvalid_width got %b want 0", cl_bus.cl_rvalid);
    end
    set_req(1'b1, 1'b1, 15'd19250, 8'h3C);
    tick();  // h=707
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr} !== {1'b1, 1'b1, 15'd19250}) begin
      errors++;
      $display("FAIL oob_grant got %h want %h", {cl_bus.cl_ack, mem_we, mem_addr},
               {1'b1, 1'b1, 15'd19250});
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    tick();  // h=708
    // Held request in blanking: grant every other cycle
    set_req(1'b1, 1'b0, 15'd5, 8'd0);
    for (int i = 0; i < 8; i++) begin
      tick();  // h=709..716
      exp_ack = (cur_h % 2) == 1;
      checks++;
      if (cl_bus.cl_ack !== exp_ack) begin
        errors++;
        $display("FAIL blank_hold_ack h=%0d got %b want %b", cur_h, cl_bus.cl_ack, exp_ack);
      end
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    repeat (4) tick();
  endtask

  task automatic test_slot_conflict();
    drive_pos(8, 4);
    set_req(1'b1, 1'b0, 15'd200, 8'd0);
    tick();  // h=9
    checks++;
    if ({cl_bus.cl_ack, mem_we, mem_addr} !== {1'b0, 1'b0, 15'd162}) begin
      errors++;
      $display("FAIL conflict_disp got %h want %h", {cl_bus.cl_ack, mem_we, mem_addr},
               {1'b0, 1'b0, 15'd162});
    end
    tick();  // h=10
    checks++;
    if ({cl_bus.cl_ack, mem_addr} !== {1'b1, 15'd200}) begin
      errors++;
      $display("FAIL conflict_client got %h want %h", {cl_bus.cl_ack, mem_addr},
               {1'b1, 15'd200});
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    tick();  // h=11
    checks++;
    if (pix_color !== 8'hB4) begin
      errors++;
      $display("FAIL conflict_pix got %h want b4", pix_color);
    end
    tick();  // h=12
    checks++;
    if ({cl_bus.cl_rvalid, cl_bus.cl_rdata} !== {1'b1, 8'hDA}) begin
      errors++;
      $display("FAIL conflict_rdata got %h want 1da", {cl_bus.cl_rvalid, cl_bus.cl_rdata});
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    int   acks;
    acks = 0;
    drive_pos(12, 4);
    set_req(1'b1, 1'b1, 15'd300, 8'h77);
    for (int i = 0; i < 16; i++) begin
      tick();  // h=13..28
      exp_ack = (cur_h % 2) == 0;
      checks++;
      if (cl_bus.cl_ack !== exp_ack || mem_we !== exp_ack) begin
        errors++;
        $display("FAIL b2b_ack h=%0d got %b%b want %b%b", cur_h, cl_bus.cl_ack, mem_we,
                 exp_ack, exp_ack);
      end
      if (cl_bus.cl_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 8) begin
      errors++;
      $display("FAIL b2b_count got %0d want 8", acks);
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    repeat (4) tick();
  endtask

  task automatic test_blank_only();
    int early;
    early = 0;
    drive_pos(100, 10);
    set_req(1'b1, 1'b0, 15'd7, 8'd0);
    while (cur_h < 640) begin
      tick();
      if (cl_bus.cl_ack === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL blank_only_early got %0d want 0", early);
    end
    tick();  // h=641
    checks++;
    if (cl_bus.cl_ack !== 1'b1) begin
      errors++;
      $display("FAIL blank_only_ack got %b want 1", cl_bus.cl_ack);
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    repeat (4) tick();
  endtask

  task automatic test_reset_midflight();
    logic [44:0] outs;
    int          pulses;
    pulses = 0;
    drive_pos(720, 4);
    set_req(1'b1, 1'b0, 15'd100, 8'd0);
    tick();  // h=721
    checks++;
    if (cl_bus.cl_ack !== 1'b1) begin
      errors++;
      $display("FAIL mid_grant got %b want 1", cl_bus.cl_ack);
    end
    set_req(1'b0, 1'b0, 15'd0, 8'd0);
    reset = 1'b1;
    #1;
    outs = {mem_addr, mem_we, mem_wdata, cl_bus.cl_ack, cl_bus.cl_rvalid,
            cl_bus.cl_rdata, pix_color, pix_hsync, pix_vsync, pix_active};
    checks++;
    if (outs !== 45'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h want 0", outs);
    end
    tick();
    reset = 1'b0;
    repeat (4) begin
      tick();
      if (cl_bus.cl_rvalid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL mid_rvalid got %0d want 0", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_scanout();
    test_client();
`ifdef VRAM_BLANK_ONLY_EN
    test_blank_only();
`else
    test_slot_conflict();
    test_back_to_back();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
